// File: rtl/s298_oracle_driver.sv
// Stimulus/response harness for the s298 benchmark: LFSR vectors on G0..G2, DUT reset control, 16-bit MISR signature.
// Optional golden-signature comparator enabled by defining S298_ORACLE_GOLDEN_CMP_EN.
module s298_oracle_driver #(
  parameter int unsigned NUM_CYCLES = 256,
  parameter int unsigned RST_CYCLES = 2,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5,
  parameter logic [15:0] MISR_SEED  = 16'h0000
) (
  input  logic        CK,
  input  logic        RN,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [15:0] signature,
  output logic [15:0] cycle_cnt,
  output logic        dut_rn,
  output logic        dut_g0,
  output logic        dut_g1,
  output logic        dut_g2,
  input  logic [5:0]  dut_out
`ifdef S298_ORACLE_GOLDEN_CMP_EN
  ,
  input  logic [15:0] golden_sig,
  output logic        match
`endif
);

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [7:0]  SEED_EFF = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  localparam logic [15:0] LAST_K   = 16'(NUM_CYCLES - 1);
  localparam logic [3:0]  LAST_R   = 4'(RST_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_RST, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t      state, state_nxt;
  logic [7:0]  lfsr, lfsr_nxt;
  logic [15:0] misr, misr_nxt, cnt_nxt;
  logic [3:0]  rst_cnt, rst_cnt_nxt;
  logic        busy_nxt, done_nxt, rn_nxt;
  logic [2:0]  g_nxt;

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  function automatic logic [15:0] misr_step(input logic [15:0] m, input logic [5:0] d);
    return {m[14:0], 1'b0} ^ (m[15] ? 16'h100B : 16'h0000) ^ {10'b0, d};
  endfunction

  always_comb begin
    state_nxt   = state;
    lfsr_nxt    = lfsr;
    misr_nxt    = misr;
    cnt_nxt     = cycle_cnt;
    rst_cnt_nxt = rst_cnt;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nxt   = S_RST;
          lfsr_nxt    = SEED_EFF;
          misr_nxt    = MISR_SEED;
          cnt_nxt     = 16'd0;
          rst_cnt_nxt = 4'd0;
        end
      end
      S_RST: begin
        if (rst_cnt == LAST_R) state_nxt = S_RUN;
        else rst_cnt_nxt = rst_cnt + 4'd1;
      end
      S_RUN: begin
        // DUT outputs lag one cycle, so vector 0 has no response to capture yet.
        lfsr_nxt = lfsr_step(lfsr);
        cnt_nxt  = cycle_cnt + 16'd1;
        if (cycle_cnt != 16'd0) misr_nxt = misr_step(misr, dut_out);
        if (cycle_cnt == LAST_K) state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        misr_nxt  = misr_step(misr, dut_out);
        state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase

    // Outputs are computed from the next state so they can all be registered.
    busy_nxt = (state_nxt == S_RST) || (state_nxt == S_RUN) || (state_nxt == S_FLUSH);
    done_nxt = (state_nxt == S_DONE);
    rn_nxt   = (state_nxt != S_RST);
    g_nxt    = (state_nxt == S_RUN) ? lfsr_nxt[2:0] : 3'b000;
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state     <= S_IDLE;
      lfsr      <= SEED_EFF;
      misr      <= 16'h0000;
      cycle_cnt <= 16'd0;
      rst_cnt   <= 4'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      dut_rn    <= 1'b1;
      {dut_g2, dut_g1, dut_g0} <= 3'b000;
    end else begin
      state     <= state_nxt;
      lfsr      <= lfsr_nxt;
      misr      <= misr_nxt;
      cycle_cnt <= cnt_nxt;
      rst_cnt   <= rst_cnt_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      dut_rn    <= rn_nxt;
      {dut_g2, dut_g1, dut_g0} <= g_nxt;
    end
  end

  assign signature = misr;

`ifdef S298_ORACLE_GOLDEN_CMP_EN
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) match <= 1'b0;
    else     match <= done_nxt && (misr_nxt == golden_sig);
  end
`endif

endmodule

// File: tb/tb_s298_oracle_driver.sv
// Randomized self-checking bench for s298_oracle_driver against a cycle-timeline reference model.
// Two instances: default configuration and a one-vector, zero-seed configuration.
module tb_s298_oracle_driver;

  localparam int N_A = 256;
  localparam int R_A = 2;
  localparam logic [7:0]  SEED_A  = 8'hA5;
  localparam logic [15:0] MSEED_A = 16'h0000;
  localparam int N_B = 1;
  localparam int R_B = 3;
  localparam logic [7:0]  SEED_B  = 8'h00;
  localparam logic [15:0] MSEED_B = 16'h1234;

  logic        CK = 1'b0;
  logic        RN = 1'b1;
  logic        start = 1'b0;
  logic        sel = 1'b0;
  logic [5:0]  dut_out = 6'h00;
  logic [5:0]  pat [0:299];
  int          tests = 0;
  int          fails = 0;
  logic [15:0] sig_ref, sig_tmp;

  logic        a_busy, a_done, a_rn, a_g0, a_g1, a_g2;
  logic [15:0] a_sig, a_cnt;
  logic        b_busy, b_done, b_rn, b_g0, b_g1, b_g2;
  logic [15:0] b_sig, b_cnt;
  logic        a_start, b_start;
  logic [5:0]  obs_ctl;
  logic [15:0] obs_sig, obs_cnt;

  assign a_start = start & ~sel;
  assign b_start = start & sel;
  assign obs_ctl = sel ? {b_busy, b_done, b_rn, b_g2, b_g1, b_g0}
                       : {a_busy, a_done, a_rn, a_g2, a_g1, a_g0};
  assign obs_sig = sel ? b_sig : a_sig;
  assign obs_cnt = sel ? b_cnt : a_cnt;

`ifdef S298_ORACLE_GOLDEN_CMP_EN
  logic [15:0] golden_sig = 16'h0000;
  logic        a_match, b_match;
`endif

  always #5 CK = ~CK;

  s298_oracle_driver #(.NUM_CYCLES(N_A), .RST_CYCLES(R_A), .LFSR_SEED(SEED_A), .MISR_SEED(MSEED_A)) dut_a (
    .CK(CK), .RN(RN), .start(a_start), .busy(a_busy), .done(a_done),
    .signature(a_sig), .cycle_cnt(a_cnt), .dut_rn(a_rn),
    .dut_g0(a_g0), .dut_g1(a_g1), .dut_g2(a_g2), .dut_out(dut_out)
`ifdef S298_ORACLE_GOLDEN_CMP_EN
    , .golden_sig(golden_sig), .match(a_match)
`endif
  );

  s298_oracle_driver #(.NUM_CYCLES(N_B), .RST_CYCLES(R_B), .LFSR_SEED(SEED_B), .MISR_SEED(MSEED_B)) dut_b (
    .CK(CK), .RN(RN), .start(b_start), .busy(b_busy), .done(b_done),
    .signature(b_sig), .cycle_cnt(b_cnt), .dut_rn(b_rn),
    .dut_g0(b_g0), .dut_g1(b_g1), .dut_g2(b_g2), .dut_out(dut_out)
`ifdef S298_ORACLE_GOLDEN_CMP_EN
    , .golden_sig(golden_sig), .match(b_match)
`endif
  );

  function automatic logic [7:0] model_lfsr(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  function automatic logic [15:0] model_misr(input logic [15:0] m, input logic [5:0] d);
    logic [16:0] wide;
    wide = {1'b0, m} << 1;
    if (wide[16]) wide = wide ^ 17'h1100B;
    return wide[15:0] ^ {10'b0, d};
  endfunction

  task automatic fill_pat(input int mode);
    for (int i = 0; i < 300; i++)
      pat[i] = (mode == 0) ? 6'($urandom) : (mode == 1) ? 6'h01 : 6'h00;
  endtask

  // One full run from IDLE/DONE; every cycle is checked against the expected timeline.
  task automatic do_run(input int n, input int r, input logic [7:0] seed, input logic [15:0] mseed,
                        input int abort_at, input bit poke, output logic [15:0] sig);
    logic [7:0]  l;
    logic [15:0] m;
    l = (seed == 8'h00) ? 8'h01 : seed;
    m = mseed;
    sig = 16'h0000;
    start = 1'b1;
    @(negedge CK);
    start = 1'b0;
    for (int i = 0; i < r; i++) begin
      tests++;
      if (obs_ctl !== 6'b100000 || obs_cnt !== 16'd0) begin
        fails++;
        $display("[TB] FAIL rst_phase cyc %0d got ctl=%b cnt=%0d exp ctl=100000 cnt=0", i, obs_ctl, obs_cnt);
      end
      @(negedge CK);
    end
    for (int k = 0; k < n; k++) begin
      tests++;
      if (obs_ctl !== {3'b101, l[2:0]} || obs_cnt !== 16'(k)) begin
        fails++;
        $display("[TB] FAIL run_vec k=%0d got ctl=%b cnt=%0d exp ctl=%b cnt=%0d",
                 k, obs_ctl, obs_cnt, {3'b101, l[2:0]}, k);
      end
      if (k == abort_at) begin
        RN = 1'b0;
        #1;
        tests++;
        if (obs_ctl !== 6'b001000 || obs_sig !== 16'h0000 || obs_cnt !== 16'd0) begin
          fails++;
          $display("[TB] FAIL mid_reset got ctl=%b sig=%h cnt=%0d exp ctl=001000 sig=0000 cnt=0",
                   obs_ctl, obs_sig, obs_cnt);
        end
        #1 RN = 1'b1;
        @(negedge CK);
        return;
      end
      dut_out = pat[k];
      if (k >= 1) m = model_misr(m, pat[k]);
      l = model_lfsr(l);
      start = poke && (k >= 10) && (k <= 12);
      @(negedge CK);
    end
    start = 1'b0;
    tests++;
    if (obs_ctl !== 6'b101000 || obs_cnt !== 16'(n)) begin
      fails++;
      $display("[TB] FAIL flush got ctl=%b cnt=%0d exp ctl=101000 cnt=%0d", obs_ctl, obs_cnt, n);
    end
    dut_out = pat[n];
    m = model_misr(m, pat[n]);
    @(negedge CK);
    tests++;
    if (obs_ctl !== 6'b011000 || obs_cnt !== 16'(n) || obs_sig !== m) begin
      fails++;
      $display("[TB] FAIL done got ctl=%b cnt=%0d sig=%h exp ctl=011000 cnt=%0d sig=%h",
               obs_ctl, obs_cnt, obs_sig, n, m);
    end
    sig = m;
  endtask

  task automatic test_reset;
    @(negedge CK);
    RN = 1'b0;
    #1;
    tests++;
    if ({a_busy, a_done, a_rn, a_g2, a_g1, a_g0, a_sig, a_cnt} !== {6'b001000, 32'h0}) begin
      fails++;
      $display("[TB] FAIL reset_a got ctl=%b sig=%h cnt=%0d exp ctl=001000 sig=0 cnt=0",
               {a_busy, a_done, a_rn, a_g2, a_g1, a_g0}, a_sig, a_cnt);
    end
    tests++;
    if ({b_busy, b_done, b_rn, b_g2, b_g1, b_g0, b_sig, b_cnt} !== {6'b001000, 32'h0}) begin
      fails++;
      $display("[TB] FAIL reset_b got ctl=%b sig=%h cnt=%0d exp ctl=001000 sig=0 cnt=0",
               {b_busy, b_done, b_rn, b_g2, b_g1, b_g0}, b_sig, b_cnt);
    end
    @(negedge CK);
    RN = 1'b1;
    for (int i = 0; i < 10; i++) begin
      dut_out = 6'($urandom);
      @(negedge CK);
      tests++;
      if (obs_ctl !== 6'b001000 || obs_sig !== 16'h0000) begin
        fails++;
        $display("[TB] FAIL idle cyc %0d got ctl=%b sig=%h exp ctl=001000 sig=0000", i, obs_ctl, obs_sig);
      end
    end
  endtask

  task automatic test_vector_sequence;
    sel = 1'b0;
    fill_pat(0);
    do_run(N_A, R_A, SEED_A, MSEED_A, -1, 1'b0, sig_ref);
  endtask

  task automatic test_back_to_back;
    do_run(N_A, R_A, SEED_A, MSEED_A, -1, 1'b0, sig_tmp);
    tests++;
    if (sig_tmp !== sig_ref || a_sig !== sig_ref) begin
      fails++;
      $display("[TB] FAIL back_to_back got %h exp %h", a_sig, sig_ref);
    end
  endtask

  task automatic test_misr_patterns;
    fill_pat(1);
    do_run(N_A, R_A, SEED_A, MSEED_A, -1, 1'b0, sig_tmp);
    fill_pat(2);
    do_run(N_A, R_A, SEED_A, MSEED_A, -1, 1'b0, sig_tmp);
    tests++;
    if (a_sig !== 16'h0000) begin
      fails++;
      $display("[TB] FAIL misr_zero got %h exp 0000", a_sig);
    end
  endtask

  task automatic test_start_while_busy;
    fill_pat(0);
    do_run(N_A, R_A, SEED_A, MSEED_A, -1, 1'b1, sig_tmp);
  endtask

  task automatic test_mid_run_reset;
    fill_pat(0);
    do_run(N_A, R_A, SEED_A, MSEED_A, -1, 1'b0, sig_ref);
    do_run(N_A, R_A, SEED_A, MSEED_A, 50, 1'b0, sig_tmp);
    do_run(N_A, R_A, SEED_A, MSEED_A, -1, 1'b0, sig_tmp);
    tests++;
    if (a_sig !== sig_ref) begin
      fails++;
      $display("[TB] FAIL rerun_after_reset got %h exp %h", a_sig, sig_ref);
    end
  endtask

  task automatic test_done_hold;
    sig_tmp = a_sig;
    for (int i = 0; i < 5; i++) begin
      dut_out = 6'($urandom);
      @(negedge CK);
      tests++;
      if (obs_ctl !== 6'b011000 || obs_sig !== sig_tmp || obs_cnt !== 16'(N_A)) begin
        fails++;
        $display("[TB] FAIL done_hold got ctl=%b sig=%h cnt=%0d exp ctl=011000 sig=%h cnt=%0d",
                 obs_ctl, obs_sig, obs_cnt, sig_tmp, N_A);
      end
    end
  endtask

  task automatic test_small_config;
    sel = 1'b1;
    for (int j = 0; j < 3; j++) begin
      fill_pat(0);
      do_run(N_B, R_B, SEED_B, MSEED_B, -1, 1'b0, sig_tmp);
    end
    sel = 1'b0;
  endtask

`ifdef S298_ORACLE_GOLDEN_CMP_EN
  task automatic test_golden;
    sel = 1'b0;
    fill_pat(0);
    do_run(N_A, R_A, SEED_A, MSEED_A, -1, 1'b0, sig_ref);
    golden_sig = sig_ref;
    do_run(N_A, R_A, SEED_A, MSEED_A, -1, 1'b0, sig_tmp);
    tests++;
    if (a_match !== 1'b1) begin
      fails++;
      $display("[TB] FAIL match_equal got %b exp 1", a_match);
    end
    golden_sig = sig_ref ^ 16'h0001;
    @(negedge CK);
    tests++;
    if (a_match !== 1'b0) begin
      fails++;
      $display("[TB] FAIL match_flip got %b exp 0", a_match);
    end
    golden_sig = sig_ref;
    @(negedge CK);
    tests++;
    if (a_match !== 1'b1) begin
      fails++;
      $display("[TB] FAIL match_restore got %b exp 1", a_match);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_vector_sequence;
    test_back_to_back;
    test_done_hold;
    test_misr_patterns;
    test_start_while_busy;
    test_mid_run_reset;
    test_small_config;
`ifdef S298_ORACLE_GOLDEN_CMP_EN
    test_golden;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/s298_oracle_driver.md
Name: s298_oracle_driver

Overview:
- Stimulus and response end of the s298 benchmark's primary I/O, used as the functional oracle harness for camouflaged s298 netlists.
- Generates pseudo-random vectors on G0/G1/G2, controls the DUT flop reset, and compacts the six primary outputs (G66, G67, G117, G118, G132, G133) into a 16-bit MISR signature.
- Original and camouflaged netlists are compared by signature.

Parameters:
- NUM_CYCLES, 256, number of vectors applied per run; legal range 1..65535.
- RST_CYCLES, 2, number of cycles dut_rn is held low before vectors start; legal range 1..15.
- LFSR_SEED, 8'hA5, LFSR value loaded on start; 8'h00 is replaced by 8'h01.
- MISR_SEED, 16'h0000, MISR value loaded on start.

Ports:
- CK  in  1  clock; rising edge.
- RN  in  1  asynchronous reset, active-low.
- start  in  1  level; sampled only in IDLE or DONE.
- busy  out  1  high in RST, RUN and FLUSH.
- done  out  1  high in DONE.
- signature  out  16  MISR contents; stable and valid while done=1.
- cycle_cnt  out  16  count of vectors applied in the current run.
- dut_rn  out  1  drives the RN pin of all DUT flops.
- dut_g0  out  1  drives DUT input G0.
- dut_g1  out  1  drives DUT input G1.
- dut_g2  out  1  drives DUT input G2.
- dut_out  in  6  DUT outputs packed as {G133,G132,G118,G117,G67,G66}; bit 0 is G66.

Behaviour:
- Reset (RN=0, asynchronous): state=IDLE, busy=0, done=0, signature=16'h0000, cycle_cnt=0, dut_rn=1, dut_g0..dut_g2=0, lfsr=LFSR_SEED (with the 0 substitution), rst_cnt=0.
- States: IDLE, RST, RUN, FLUSH, DONE. All outputs are registered.
- IDLE, start=1: go to RST. Load lfsr=LFSR_SEED, misr=MISR_SEED, cycle_cnt=0, rst_cnt=0.
- RST:
  - dut_rn=0 and dut_g*=0.
  - After RST_CYCLES cycles in RST, go to RUN.
- RUN cycle k (k = 0..NUM_CYCLES-1):
  - dut_rn=1; {dut_g2,dut_g1,dut_g0} = lfsr[2:0].
  - At the closing edge: lfsr advances; cycle_cnt increments.
  - At the closing edge, for k≥1 only: misr captures dut_out. This is the DUT's response to vector k-1, since the DUT outputs are flop outputs with one-cycle latency.
  - After k = NUM_CYCLES-1, go to FLUSH.
- FLUSH (1 cycle):
  - dut_g*=0.
  - misr captures dut_out, the response to the final vector.
  - Go to DONE. Total MISR samples = NUM_CYCLES.
- DONE:
  - done=1; signature=misr held.
  - start=1 restarts exactly as from IDLE; done drops on the next edge.
- LFSR: 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1.
  - fb = l[7]^l[5]^l[4]^l[3]
  - l_next = {l[6:0],fb}
- MISR: 16-bit, polynomial x^16+x^12+x^3+x+1.
  - m_next = {m[14:0],1'b0} ^ (m[15] ? 16'h100B : 16'h0000) ^ {10'b0,dut_out}
- signature output mirrors misr in every state. It is only guaranteed valid while done=1.
- Boundary conditions:
  - start while busy=1: ignored.
  - start held high in DONE: run restarts immediately, so back-to-back runs are permitted.
  - NUM_CYCLES=1: exactly one RUN cycle, then FLUSH; one MISR sample.
  - cycle_cnt never exceeds NUM_CYCLES; it holds its final value through DONE.
  - RN asserted mid-run: immediate return to reset values. dut_rn goes to 1, so the DUT reset is released and the DUT is no longer driven into reset by the driver. No partial signature is retained.
- Handshake: one run per start acceptance. There is no abort input other than RN.

Optional Feature:
- Macro: S298_ORACLE_GOLDEN_CMP_EN.
- Defined:
  - Adds input port golden_sig (16 bits) and output port match (1 bit).
  - match is registered and =1 only in DONE when misr==golden_sig; otherwise 0.
  - match resets to 0.
- Undefined: neither port exists, and there is no comparator logic.

Test Plan:
- Reset then idle: RN pulse, start=0 for 10 cycles -> busy=0, done=0, dut_rn=1, dut_g*=0, signature=16'h0000.
- Vector sequence: defaults, start=1 for 1 cycle ->
  - dut_rn=0 for exactly 2 cycles.
  - First RUN cycle: {g2,g1,g0}=3'b101 (lfsr 8'hA5).
  - Second RUN cycle: 3'b010 (lfsr 8'h4A).
  - cycle_cnt reaches 256; done rises 1 cycle after the last vector.
- MISR arithmetic: NUM_CYCLES=2, MISR_SEED=0, dut_out tied 6'h01 -> signature=16'h0003. With dut_out tied 6'h00 -> 16'h0000.
- Start while busy: pulse start during RUN -> no effect; done asserts after exactly NUM_CYCLES RUN cycles plus 1 FLUSH cycle.
- Mid-run reset: assert RN at RUN cycle 50 ->
  - busy=0, signature=0, dut_rn=1 immediately.
  - A new start produces a signature identical to an uninterrupted run.
- Golden compare (macro defined): run the actual s298 netlist and record its signature, then rerun with golden_sig set to that value -> match=1. Flip golden_sig bit 0 -> match=0.
